round_key_buffer: RTL and testbench
===================================

# round_key_buffer

Stores the fifteen 128-bit round keys of one AES-256 key schedule as the key expansion stage emits them, one per round, then serves any round key by index with one-cycle latency. It sits directly downstream of the key expansion stage and feeds the AddRoundKey / I_AddRoundKey datapath. The schedule is expanded once per key; every later CTR block reads stored keys, forward or reverse, without re-running expansion.

## Interface
- KEY_WIDTH, 256, cipher key width; the round key width is KEY_WIDTH/2 = 128.
- NR, 14, number of AES rounds; NR+1 = 15 keys are stored, indices 0..14.
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- key_load  input  1  one-cycle pulse; invalidates all stored keys and starts a new fill.
- wr_en  input  1  write strobe from the key expansion side.
- wr_round  input  4  index of the key presented on wr_key.
- wr_key  input  KEY_WIDTH/2  round key from the key expansion stage.
- rd_en  input  1  read request.
- rd_round  input  4  index to read.
- rd_key_o  output  KEY_WIDTH/2  registered read data.
- rd_valid_o  output  1  one-cycle pulse: rd_key_o holds a stored key.
- ready_o  output  1  all NR+1 keys are stored.
- wr_err_o  output  1  sticky: a write was rejected.

## Operation
- FSM states: EMPTY, FILLING, READY. Reset goes to EMPTY.
- EMPTY -> FILLING on key_load. FILLING -> READY on the accepted write of index NR. Any state -> FILLING on key_load.
- key_load clears the 15-bit valid bitmap, wr_ptr, ready_o and wr_err_o. A write in the same cycle as key_load is discarded and does not set wr_err_o.
- Write acceptance requires state FILLING, wr_en=1 and wr_round == wr_ptr. On acceptance: store wr_key at that index, set its valid bit, increment wr_ptr.
- Write rejection covers any other wr_en=1: state EMPTY or READY, or an out-of-order index. A rejected write leaves the storage, bitmap and wr_ptr unchanged and sets wr_err_o, which stays set until key_load or reset.
- Read hit: rd_en=1, rd_round <= NR, and the valid bit is set. Response next cycle is rd_key_o = stored key, rd_valid_o = 1.
- Read miss: an unwritten index, or rd_round > NR. Response next cycle is rd_valid_o = 0, rd_key_o = 0.
- With rd_en=0, rd_valid_o = 0 and rd_key_o holds its last value.
- Reads are legal in every state, so in FILLING earlier rounds can be read while later rounds are still being written.
- Key storage array is not reset. The bitmap guarantees stale data is never flagged valid.

## Timing
- Reset values: rd_key_o = 0, rd_valid_o = 0, ready_o = 0, wr_err_o = 0; state EMPTY, wr_ptr = 0, bitmap = 0.
- Reset asserted mid-fill or mid-read: all outputs and state return to their reset values immediately (asynchronous). The next fill requires a fresh key_load.
- Write latency: a key accepted at edge N is readable by a read request sampled at edge N+1, with data at N+2.
- Read latency: 1 cycle, fully pipelined, one read per cycle.
- ready_o rises the cycle after the edge that accepts index NR and stays high until key_load or reset.
- A simultaneous read and write of the same index in the same cycle reads the bitmap before the write; the result depends on the macro below.

## Configuration
- RKB_WR_FWD_EN defined: a same-cycle read of the index being accepted returns wr_key with rd_valid_o = 1 on the next cycle, giving zero-bubble streaming behind key expansion.
- RKB_WR_FWD_EN undefined: that read is a miss (rd_valid_o = 0, rd_key_o = 0). No forwarding mux is built.

## Test plan
- Reset, then key_load, then 15 in-order writes of the FIPS-197 AES-256 schedule for key 000102..1f -> ready_o = 1 one cycle after the write of index 14; wr_err_o = 0.
- Reads of indices 0, 1, 2 and 14 -> next cycle rd_valid_o = 1 and:
  - index 0 returns 000102030405060708090a0b0c0d0e0f;
  - index 1 returns 101112131415161718191a1b1c1d1e1f;
  - index 2 returns a573c29fa176c498a97fce93a572c09c;
  - index 14 returns 24fc79ccbf0979e9371ac23c6d68de36.
- Mid-fill after 3 writes: read index 2 -> valid hit; read index 5 -> rd_valid_o = 0, rd_key_o = 0; read index 15 -> miss.
- Write of index 4 when wr_ptr = 3, and a write while in READY -> each rejected; wr_err_o = 1 and sticky; stored contents unchanged; key_load clears wr_err_o.
- Read and write of index 7 in the same cycle:
  - with RKB_WR_FWD_EN -> valid and equal to wr_key;
  - without it -> miss.
- Assert rst_n low after 8 writes -> outputs return to reset values at once. After release, a read of index 0 misses until a new key_load and write.

Source files
------------

// File: rtl/round_key_buffer.sv
// Stores the 15 AES-256 round keys as key expansion emits them and serves any key by index one cycle later.
// Optional build macro RKB_WR_FWD_EN forwards a key being written to a same-cycle read of that index.
module round_key_buffer #(
    parameter int KEY_WIDTH = 256,
    parameter int NR        = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_load,
    input  logic                   wr_en,
    input  logic [3:0]             wr_round,
    input  logic [KEY_WIDTH/2-1:0] wr_key,
    input  logic                   rd_en,
    input  logic [3:0]             rd_round,
    output logic [KEY_WIDTH/2-1:0] rd_key_o,
    output logic                   rd_valid_o,
    output logic                   ready_o,
    output logic                   wr_err_o
);
    localparam int         RK_W = KEY_WIDTH / 2;
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {EMPTY, FILLING, READY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wr_ptr_q, wr_ptr_d;
    logic [NR:0]     valid_q, valid_d;
    logic            wr_err_q, wr_err_d;
    logic [RK_W-1:0] rd_key_q, rd_key_d;
    logic            rd_valid_q, rd_valid_d;
    logic            wr_acc;
    logic            rd_hit;
    logic            rd_fwd;
    logic [RK_W-1:0] mem [0:NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            valid_q    <= '0;
            wr_err_q   <= 1'b0;
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            wr_err_q   <= wr_err_d;
            rd_key_q   <= rd_key_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset; the valid bitmap masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_key;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        wr_err_d = wr_err_q;
        wr_acc   = 1'b0;
        if (key_load) begin
            // A write coinciding with key_load is dropped silently.
            state_d  = FILLING;
            wr_ptr_d = '0;
            valid_d  = '0;
            wr_err_d = 1'b0;
        end else if (wr_en) begin
            if (state_q == FILLING && wr_round == wr_ptr_q) begin
                wr_acc            = 1'b1;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + 4'd1;
                if (wr_round == LAST) begin
                    state_d = READY;
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Hit test uses the bitmap as it stood before this cycle's write.
    assign rd_hit = rd_en && (rd_round <= LAST) && valid_q[rd_round];

`ifdef RKB_WR_FWD_EN
    assign rd_fwd = rd_en && wr_acc && (rd_round == wr_round);
`else
    assign rd_fwd = 1'b0;
`endif

    always_comb begin
        rd_key_d   = rd_key_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rd_key_d = '0;
            if (rd_hit) begin
                rd_key_d   = mem[rd_round];
                rd_valid_d = 1'b1;
            end else if (rd_fwd) begin
                rd_key_d   = wr_key;
                rd_valid_d = 1'b1;
            end
        end
    end

    assign rd_key_o   = rd_key_q;
    assign rd_valid_o = rd_valid_q;
    assign ready_o    = (state_q == READY);
    assign wr_err_o   = wr_err_q;
endmodule

// File: tb/tb_round_key_buffer.sv
// Directed bench for round_key_buffer using the AES-256 schedule of key 000102..1f.
module tb_round_key_buffer;
    logic         clk;
    logic         rst_n;
    logic         key_load;
    logic         wr_en;
    logic [3:0]   wr_round;
    logic [127:0] wr_key;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key_o;
    logic         rd_valid_o;
    logic         ready_o;
    logic         wr_err_o;

    int errors = 0;
    int checks = 0;
    logic [127:0] rk [0:14];

    round_key_buffer dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load),
        .wr_en(wr_en), .wr_round(wr_round), .wr_key(wr_key),
        .rd_en(rd_en), .rd_round(rd_round),
        .rd_key_o(rd_key_o), .rd_valid_o(rd_valid_o),
        .ready_o(ready_o), .wr_err_o(wr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [127:0] k);
        wr_en = 1'b1; wr_round = idx; wr_key = k;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_en = 1'b1; rd_round = idx;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (rd_key_o !== 128'h0 || rd_valid_o !== 1'b0 || ready_o !== 1'b0 || wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got key=%h vld=%b rdy=%b err=%b, want all zero",
                     rd_key_o, rd_valid_o, ready_o, wr_err_o);
        end
    endtask

    task automatic test_fill_and_read();
        do_load();
        for (int i = 0; i < 15; i++) begin
            do_write(4'(i), rk[i]);
            if (i == 13) begin
                checks++;
                if (ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_early: got %b want 0", ready_o);
                end
            end
        end
        checks++;
        if (ready_o !== 1'b1 || wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_fill: got rdy=%b err=%b want rdy=1 err=0", ready_o, wr_err_o);
        end
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL read_idx0: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        do_read(4'd1);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== 128'h101112131415161718191a1b1c1d1e1f) begin
            errors++;
            $display("FAIL read_idx1: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        do_read(4'd2);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== 128'ha573c29fa176c498a97fce93a572c09c) begin
            errors++;
            $display("FAIL read_idx2: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        do_read(4'd14);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++;
            $display("FAIL read_idx14: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        step();
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++;
            $display("FAIL idle_hold: got vld=%b key=%h want vld=0 key held", rd_valid_o, rd_key_o);
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1;
        for (int i = 3; i < 15; i++) begin
            rd_round = 4'(i);
            step();
            checks++;
            if (rd_valid_o !== 1'b1 || rd_key_o !== rk[i]) begin
                errors++;
                $display("FAIL b2b_read_%0d: got vld=%b key=%h want key=%h", i, rd_valid_o, rd_key_o, rk[i]);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_midfill_and_errors();
        do_load();
        checks++;
        if (ready_o !== 1'b0 || wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL load_clears: got rdy=%b err=%b want 0 0", ready_o, wr_err_o);
        end
        for (int i = 0; i < 3; i++) do_write(4'(i), rk[i]);
        do_read(4'd2);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== rk[2]) begin
            errors++;
            $display("FAIL midfill_hit2: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        do_read(4'd5);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h0) begin
            errors++;
            $display("FAIL midfill_miss5: got vld=%b key=%h want 0 0", rd_valid_o, rd_key_o);
        end
        do_read(4'd2);
        do_read(4'd15);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h0) begin
            errors++;
            $display("FAIL midfill_miss15: got vld=%b key=%h want 0 0", rd_valid_o, rd_key_o);
        end
        do_write(4'd4, 128'hdeadbeef);
        checks++;
        if (wr_err_o !== 1'b1) begin
            errors++;
            $display("FAIL ooo_reject_err: got %b want 1", wr_err_o);
        end
        do_read(4'd4);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h0) begin
            errors++;
            $display("FAIL ooo_no_store: got vld=%b key=%h want 0 0", rd_valid_o, rd_key_o);
        end
        // wr_ptr must still be 3 after the rejected write
        for (int i = 3; i < 15; i++) do_write(4'(i), rk[i]);
        checks++;
        if (ready_o !== 1'b1 || wr_err_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_after_reject: got rdy=%b err=%b want 1 1", ready_o, wr_err_o);
        end
        do_write(4'd0, 128'hffff);
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== rk[0] || wr_err_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_reject: got vld=%b key=%h err=%b want key=%h err=1",
                     rd_valid_o, rd_key_o, wr_err_o, rk[0]);
        end
        key_load = 1'b1;
        do_write(4'd0, rk[0]);
        key_load = 1'b0;
        checks++;
        if (wr_err_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL load_clears_err: got err=%b rdy=%b want 0 0", wr_err_o, ready_o);
        end
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL load_write_dropped: got vld=%b want 0", rd_valid_o);
        end
    endtask

    task automatic test_same_cycle();
        do_load();
        for (int i = 0; i < 7; i++) do_write(4'(i), rk[i]);
        wr_en = 1'b1; wr_round = 4'd7; wr_key = rk[7];
        rd_en = 1'b1; rd_round = 4'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
`ifdef RKB_WR_FWD_EN
        if (rd_valid_o !== 1'b1 || rd_key_o !== rk[7]) begin
            errors++;
            $display("FAIL same_cycle_fwd: got vld=%b key=%h want 1 %h", rd_valid_o, rd_key_o, rk[7]);
        end
`else
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h0) begin
            errors++;
            $display("FAIL same_cycle_miss: got vld=%b key=%h want 0 0", rd_valid_o, rd_key_o);
        end
`endif
        do_read(4'd7);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== rk[7]) begin
            errors++;
            $display("FAIL after_same_cycle: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
    endtask

    task automatic test_reset_midfill();
        do_load();
        for (int i = 0; i < 8; i++) do_write(4'(i), rk[i]);
        rd_en = 1'b1; rd_round = 4'd0;
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_key_o !== 128'h0 || rd_valid_o !== 1'b0 || ready_o !== 1'b0 || wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got key=%h vld=%b rdy=%b err=%b want all zero",
                     rd_key_o, rd_valid_o, ready_o, wr_err_o);
        end
        step();
        rst_n = 1'b1;
        step();
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== 128'h0) begin
            errors++;
            $display("FAIL post_reset_miss: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
        do_write(4'd0, rk[0]);
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b0 || wr_err_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_write_reject: got vld=%b err=%b want 0 1", rd_valid_o, wr_err_o);
        end
        do_load();
        do_write(4'd0, rk[0]);
        do_read(4'd0);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== rk[0]) begin
            errors++;
            $display("FAIL refill_hit: got vld=%b key=%h", rd_valid_o, rd_key_o);
        end
    endtask

    initial begin
        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        rst_n = 1'b0; key_load = 1'b0; wr_en = 1'b0; wr_round = '0; wr_key = '0;
        rd_en = 1'b0; rd_round = '0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_fill_and_read();
        test_back_to_back();
        test_midfill_and_errors();
        test_same_cycle();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
